// File: rtl/img_gaussian_nxn_calc.sv
// Multi-channel binomial (Gaussian) NxN kernel arithmetic core.
// Weighted terms feed a registered pairwise adder tree, then one
// round/shift/saturate output stage. Latency is $clog2(N*N)+1 cke edges.
module img_gaussian_nxn_calc #(
    parameter int unsigned N        = 3,
    parameter int unsigned CHANNELS = 1,
    parameter int unsigned S_BITS   = 10,
    parameter int unsigned M_BITS   = 10,
    parameter int unsigned SHIFT    = S_BITS + ((N == 3) ? 4 : 8) - M_BITS,
    parameter bit          ROUND    = 1'b1,
    parameter bit          SATURATE = 1'b1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cke,
    input  logic                             s_mode,
    input  logic                             s_valid,
    input  logic [CHANNELS*N*N*S_BITS-1:0]   s_raw,
    output logic                             m_valid,
    output logic [CHANNELS*M_BITS-1:0]       m_raw
);

    localparam int unsigned WBITS  = (N == 3) ? 4 : 8;
    localparam int unsigned NN     = N * N;
    localparam int unsigned LEVELS = $clog2(NN);
    localparam int unsigned AW     = S_BITS + WBITS;
    localparam int unsigned CIDX   = (N / 2) * N + (N / 2);
    localparam int unsigned HALF   = (NN + 1) / 2;
    // Half-LSB rounding constant; zero when truncating or not shifting at all.
    localparam logic [AW:0] RV = (ROUND && SHIFT > 0) ? ((AW + 1)'(1) << (SHIFT - 1)) : '0;

    if (!(N == 3 || N == 5)) begin : g_bad_n
        $error("img_gaussian_nxn_calc: N must be 3 or 5");
    end
    if (SHIFT > AW) begin : g_bad_shift
        $error("img_gaussian_nxn_calc: SHIFT must be in 0..S_BITS+WBITS");
    end

    // 1-D binomial coefficient for row/column i.
    function automatic int unsigned kval(input int unsigned i);
        if (N == 3) return (i == 1) ? 2 : 1;
        return (i == 2) ? 6 : ((i == 1 || i == 3) ? 4 : 1);
    endfunction

    // Number of terms entering tree level l (level 0 sees all NN terms).
    function automatic int unsigned count_in(input int unsigned l);
        int unsigned n;
        n = NN;
        for (int unsigned j = 0; j < l; j++) n = (n + 1) / 2;
        return n;
    endfunction

    // Constant-weight multiply as a sum of shifted copies (weights are < 64).
    function automatic logic [AW-1:0] wmul(input logic [S_BITS-1:0] x, input int unsigned w);
        logic [AW-1:0] acc;
        acc = '0;
        for (int unsigned b = 0; b < 6; b++) begin
            if (w[b]) acc = acc + (AW'(x) << b);
        end
        return acc;
    endfunction

    logic [AW-1:0]     terms    [CHANNELS][NN+1];
    logic [AW-1:0]     tree_d   [LEVELS][CHANNELS][NN+1];
    logic [AW-1:0]     tree_q   [LEVELS][CHANNELS][NN+1];
    logic [S_BITS-1:0] centre_q [LEVELS][CHANNELS];
    logic [LEVELS-1:0] valid_q;
    logic [LEVELS-1:0] mode_q;
    logic [M_BITS-1:0] res      [CHANNELS];

    // Weighted window terms; the spare slot stays zero as the odd-count pad.
    always_comb begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            for (int unsigned i = 0; i < NN + 1; i++) terms[c][i] = '0;
            for (int unsigned r = 0; r < N; r++) begin
                for (int unsigned k = 0; k < N; k++) begin
                    terms[c][r*N+k] = wmul(s_raw[((c*N+r)*N+k)*S_BITS +: S_BITS],
                                           kval(r) * kval(k));
                end
            end
        end
    end

    // Pairwise adder tree next state; an odd trailing term passes through.
    always_comb begin
        for (int unsigned l = 0; l < LEVELS; l++) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                for (int unsigned i = 0; i < NN + 1; i++) tree_d[l][c][i] = '0;
            end
        end
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            for (int unsigned i = 0; i < HALF; i++) begin
                tree_d[0][c][i] = terms[c][2*i] + ((2*i + 1 < NN) ? terms[c][2*i+1] : '0);
            end
        end
        for (int unsigned l = 1; l < LEVELS; l++) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                for (int unsigned i = 0; i < HALF; i++) begin
                    if (i < count_in(l + 1)) begin
                        tree_d[l][c][i] = tree_q[l-1][c][2*i] +
                            ((2*i + 1 < count_in(l)) ? tree_q[l-1][c][2*i+1] : '0);
                    end
                end
            end
        end
    end

    // Tree, centre, valid and mode pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            mode_q  <= '0;
            for (int unsigned l = 0; l < LEVELS; l++) begin
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    centre_q[l][c] <= '0;
                    for (int unsigned i = 0; i < NN + 1; i++) tree_q[l][c][i] <= '0;
                end
            end
        end else if (cke) begin
            valid_q <= {valid_q[LEVELS-2:0], s_valid};
            mode_q  <= {mode_q[LEVELS-2:0], s_mode};
            tree_q  <= tree_d;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                centre_q[0][c] <= s_raw[(c*NN + CIDX)*S_BITS +: S_BITS];
                for (int unsigned l = 1; l < LEVELS; l++) centre_q[l][c] <= centre_q[l-1][c];
            end
        end
    end

    // Select filtered sum or scaled centre, then round, shift and saturate.
    always_comb begin : p_final
        logic [AW-1:0] sel;
        logic [AW:0]   sum;
        logic [AW:0]   shifted;
        sel     = '0;
        sum     = '0;
        shifted = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            sel     = mode_q[LEVELS-1] ? tree_q[LEVELS-1][c][0]
                                       : {centre_q[LEVELS-1][c], {WBITS{1'b0}}};
            sum     = {1'b0, sel} + RV;
            shifted = sum >> SHIFT;
            if (SATURATE && ((shifted >> M_BITS) != '0)) res[c] = '1;
            else                                         res[c] = M_BITS'(shifted);
        end
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_raw   <= '0;
        end else if (cke) begin
            m_valid <= valid_q[LEVELS-1];
            for (int unsigned c = 0; c < CHANNELS; c++) m_raw[c*M_BITS +: M_BITS] <= res[c];
        end
    end

endmodule

// File: tb/tb_img_gaussian_nxn_calc.sv
// Directed bench for img_gaussian_nxn_calc across several parameter sets.
module tb_img_gaussian_nxn_calc;

    logic         clk = 1'b0;
    logic         reset, cke, s_mode, s_valid;
    logic [89:0]  raw3, raw3t;
    logic [749:0] raw5;
    logic [107:0] raw12;
    logic         v3, v3t, v5, v12s, v12w;
    logic [9:0]   o3, o3t;
    logic [29:0]  o5;
    logic [7:0]   o12s, o12w;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    img_gaussian_nxn_calc #(.N(3)) u_g3 (
        .clk(clk), .reset(reset), .cke(cke), .s_mode(s_mode), .s_valid(s_valid),
        .s_raw(raw3), .m_valid(v3), .m_raw(o3));
    img_gaussian_nxn_calc #(.N(3), .ROUND(1'b0)) u_g3t (
        .clk(clk), .reset(reset), .cke(cke), .s_mode(s_mode), .s_valid(s_valid),
        .s_raw(raw3t), .m_valid(v3t), .m_raw(o3t));
    img_gaussian_nxn_calc #(.N(5), .CHANNELS(3)) u_g5 (
        .clk(clk), .reset(reset), .cke(cke), .s_mode(s_mode), .s_valid(s_valid),
        .s_raw(raw5), .m_valid(v5), .m_raw(o5));
    img_gaussian_nxn_calc #(.N(3), .S_BITS(12), .M_BITS(8), .SHIFT(3), .SATURATE(1'b1)) u_g12s (
        .clk(clk), .reset(reset), .cke(cke), .s_mode(s_mode), .s_valid(s_valid),
        .s_raw(raw12), .m_valid(v12s), .m_raw(o12s));
    img_gaussian_nxn_calc #(.N(3), .S_BITS(12), .M_BITS(8), .SHIFT(3), .SATURATE(1'b0)) u_g12w (
        .clk(clk), .reset(reset), .cke(cke), .s_mode(s_mode), .s_valid(s_valid),
        .s_raw(raw12), .m_valid(v12w), .m_raw(o12w));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [89:0] fill3(input int unsigned v);
        logic [89:0] w;
        for (int i = 0; i < 9; i++) w[i*10 +: 10] = 10'(v);
        return w;
    endfunction

    function automatic logic [107:0] fill12(input int unsigned v);
        logic [107:0] w;
        for (int i = 0; i < 9; i++) w[i*12 +: 12] = 12'(v);
        return w;
    endfunction

    function automatic logic [749:0] fill5(input int unsigned a, input int unsigned b,
                                           input int unsigned c);
        logic [749:0] w;
        for (int i = 0; i < 25; i++) begin
            w[i*10 +: 10]       = 10'(a);
            w[(25+i)*10 +: 10]  = 10'(b);
            w[(50+i)*10 +: 10]  = 10'(c);
        end
        return w;
    endfunction

    int          exp_q[$];
    int          sent;
    int          v;
    logic        pv;
    logic [9:0]  pr;
    bit          ck, vl;

    initial begin
        reset = 1'b1; cke = 1'b0; s_mode = 1'b0; s_valid = 1'b0;
        raw3 = '0; raw3t = '0; raw5 = '0; raw12 = '0;

        // Reset with cke low: reset must still clear everything.
        tick_n(2);
        check("reset_valid3", v3, 0);
        check("reset_raw3", o3, 0);
        check("reset_valid5", v5, 0);
        check("reset_raw5", o5, 0);
        reset = 1'b0; cke = 1'b1;
        tick();

        // N=3 full-scale then zero window, latency 5.
        s_mode = 1'b1; s_valid = 1'b1; raw3 = fill3(1023);
        tick();
        raw3 = fill3(0);
        tick();
        s_valid = 1'b0;
        tick_n(2);
        check("lat3_early", v3, 0);
        tick();
        check("full_valid", v3, 1);
        check("full_raw", o3, 1023);
        tick();
        check("zero_valid", v3, 1);
        check("zero_raw", o3, 0);
        tick();
        check("after_valid", v3, 0);
        tick_n(6);

        // Impulses and single off-centre taps.
        s_valid = 1'b1;
        raw3 = '0; raw3[40 +: 10] = 10'd1000;
        raw3t = '0; raw3t[40 +: 10] = 10'd7;
        tick();
        raw3 = '0; raw3[40 +: 10] = 10'd7;
        tick();
        raw3 = '0; raw3[0 +: 10] = 10'd160;
        tick();
        raw3 = '0; raw3[10 +: 10] = 10'd160;
        tick();
        s_valid = 1'b0;
        tick();
        check("imp1000", o3, 250);
        check("imp7_trunc_valid", v3t, 1);
        check("imp7_trunc", o3t, 1);
        tick();
        check("imp7_round", o3, 2);
        tick();
        check("corner_tap", o3, 10);
        tick();
        check("edge_tap", o3, 20);
        tick_n(6);

        // N=5, three channels, latency 6.
        s_valid = 1'b1; s_mode = 1'b1;
        raw5 = fill5(100, 200, 300);
        tick();
        raw5 = '0; raw5[24*10 +: 10] = 10'd256;
        tick();
        raw5 = '0; raw5[(25+7)*10 +: 10] = 10'd100; raw5[(50+12)*10 +: 10] = 10'd1000;
        tick();
        s_mode = 1'b0;
        raw5 = '0; raw5[12*10 +: 10] = 10'd1000; raw5[(25+12)*10 +: 10] = 10'd5;
        raw5[(50+12)*10 +: 10] = 10'd1023;
        tick();
        s_valid = 1'b0; s_mode = 1'b1; raw5 = fill5(999, 999, 999);
        tick();
        check("lat5_early", v5, 0);
        tick();
        check("uniform5_valid", v5, 1);
        check("uniform5", o5, {10'd300, 10'd200, 10'd100});
        tick();
        check("corner5", o5, {10'd0, 10'd0, 10'd1});
        tick();
        check("inner5", o5, {10'd141, 10'd9, 10'd0});
        tick();
        check("bypass5", o5, {10'd1023, 10'd5, 10'd1000});
        tick_n(6);

        // Mode toggles every window; centre 500, neighbours 100.
        raw3 = fill3(100); raw3[40 +: 10] = 10'd500;
        for (int i = 0; i < 10; i++) begin
            s_valid = (i < 6);
            s_mode  = (i % 2 == 0);
            tick();
            if (i >= 4) begin
                check("toggle_valid", v3, 1);
                check("toggle_raw", o3, ((i - 4) % 2 == 0) ? 200 : 500);
            end
        end
        s_valid = 1'b0; s_mode = 1'b1;
        tick_n(6);

        // Random cke and valid gaps against an ordered expectation queue.
        sent = 0;
        for (int cyc = 0; cyc < 600 && !(sent == 40 && exp_q.size() == 0); cyc++) begin
            ck = (sent >= 40) ? 1'b1 : ($urandom_range(0, 1) == 1);
            vl = (sent < 40) && ($urandom_range(0, 3) != 0);
            v  = (sent * 37 + 11) % 1024;
            cke = ck; s_valid = vl; s_mode = 1'b1; raw3 = fill3(v);
            pv = v3; pr = o3;
            tick();
            if (ck && vl) begin
                exp_q.push_back(v);
                sent++;
            end
            if (!ck) begin
                check("hold_valid", v3, pv);
                check("hold_raw", o3, pr);
            end else if (v3) begin
                if (exp_q.size() == 0) check("stream_extra", v3, 0);
                else                   check("stream_data", o3, exp_q.pop_front());
            end
        end
        cke = 1'b1; s_valid = 1'b0;
        check("stream_sent", sent, 40);
        check("stream_left", exp_q.size(), 0);
        tick_n(6);

        // Reset with three windows in flight.
        s_valid = 1'b1; raw3 = fill3(300);
        tick_n(3);
        reset = 1'b1; s_valid = 1'b0;
        tick();
        check("midreset_valid", v3, 0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("no_stale", v3, 0);
        end
        s_valid = 1'b1; raw3 = fill3(77);
        tick();
        s_valid = 1'b0;
        tick_n(3);
        check("post_reset_early", v3, 0);
        tick();
        check("post_reset_valid", v3, 1);
        check("post_reset_raw", o3, 77);
        tick_n(6);

        // 12-bit in, 8-bit out, SHIFT=3: saturate versus wrap, then bypass.
        s_valid = 1'b1; s_mode = 1'b1; raw12 = fill12(4095);
        tick();
        s_mode = 1'b0; raw12[48 +: 12] = 12'd100;
        tick();
        s_valid = 1'b0; s_mode = 1'b1;
        tick_n(3);
        check("sat_valid", v12s, 1);
        check("sat_raw", o12s, 255);
        check("wrap_valid", v12w, 1);
        check("wrap_raw", o12w, 254);
        tick();
        check("bypass12_sat", o12s, 200);
        check("bypass12_wrap", o12w, 200);
        tick_n(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
